interface_tx_arbiter_2to1: RTL and testbench

Frame-aware transmit arbiter that shares one 8-bit GMII-side transmit byte stream between the control-interface source and the network-interface source. It grants the stream to one source per frame using a request/grant handshake and round-robin tie-break. It forwards only the owner's bytes through a one-cycle registered path and enforces a programmable inter-frame gap before re-arbitrating. It sits in front of the 1G MAC transmit path and replaces static interface selection with per-frame sharing.

---
 rtl/interface_tx_arbiter_2to1.sv | 156 +++++++++++++++
 tb/tb_interface_tx_arbiter_2to1.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interface_tx_arbiter_2to1.sv
// interface_tx_arbiter_2to1
// Frame-aware 2:1 arbiter in front of the 1G MAC transmit path. One source owns the
// 8-bit transmit byte stream per frame, chosen by request/grant with round-robin tie-break.
// The owner's bytes are forwarded through one register stage, and an inter-frame gap is
// enforced before re-arbitrating.
//
// Ports:
//   i_clk, i_rst_n                       clock, asynchronous active-low reset
//   i_req_ctrl / o_gnt_ctrl              control source request / grant
//   iv_data_ctrl, i_data_wr_ctrl         control source byte and byte valid
//   i_req_network / o_gnt_network        network source request / grant
//   iv_data_network, i_data_wr_network   network source byte and byte valid
//   ov_data, o_data_wr                   forwarded byte and valid (one cycle behind owner)
//   o_interface_type                     current/last owner: 0 network, 1 ctrl
//   o_timeout_pulse                      one-cycle pulse when a grant is revoked by start timeout
module interface_tx_arbiter_2to1 #(
  parameter int unsigned IFG_CYCLES    = 12,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_ctrl,
  output logic       o_gnt_ctrl,
  input  logic [7:0] iv_data_ctrl,
  input  logic       i_data_wr_ctrl,
  input  logic       i_req_network,
  output logic       o_gnt_network,
  input  logic [7:0] iv_data_network,
  input  logic       i_data_wr_network,
  output logic [7:0] ov_data,
  output logic       o_data_wr,
  output logic       o_interface_type,
  output logic       o_timeout_pulse
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWaitStart = 2'd1;
  localparam logic [1:0] StXfer      = 2'd2;
  localparam logic [1:0] StIfg       = 2'd3;

  localparam int unsigned CntMax = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(START_TIMEOUT - 1);
  localparam logic [CntW-1:0] IfgLast = CntW'(IFG_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            owner_q, owner_d;   // 1 = ctrl, 0 = network
  logic            last_q, last_d;     // owner of the last completed or timed-out grant
  logic            gnt_ctrl_q, gnt_ctrl_d;
  logic            gnt_network_q, gnt_network_d;
  logic [7:0]      data_q, data_d;
  logic            data_wr_q, data_wr_d;
  logic            timeout_q, timeout_d;

  logic            own_req, own_wr, fwd;
  logic [7:0]      own_data;

  // Only the owner's signals are ever looked at; the other source is invisible.
  assign own_req  = owner_q ? i_req_ctrl     : i_req_network;
  assign own_wr   = owner_q ? i_data_wr_ctrl : i_data_wr_network;
  assign own_data = owner_q ? iv_data_ctrl   : iv_data_network;
  assign fwd      = (state_q == StWaitStart) || (state_q == StXfer);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_d        = last_q;
    gnt_ctrl_d    = gnt_ctrl_q;
    gnt_network_d = gnt_network_q;
    timeout_d     = 1'b0;
    data_d        = fwd ? own_data : 8'h00;
    data_wr_d     = fwd & own_wr;

    case (state_q)
      StIdle: begin
        if (i_req_ctrl || i_req_network) begin
          // A tie goes to whichever source did not own the stream last.
          owner_d       = (i_req_ctrl && i_req_network) ? ~last_q : i_req_ctrl;
          gnt_ctrl_d    = owner_d;
          gnt_network_d = ~owner_d;
          cnt_d         = '0;
          state_d       = StWaitStart;
        end
      end
      StWaitStart: begin
        cnt_d = cnt_q + CntW'(1);
        if (own_wr) begin
          state_d = StXfer;
        end else if (!own_req) begin
          // Withdrawn before starting: not counted as a turn for round-robin.
          gnt_ctrl_d    = 1'b0;
          gnt_network_d = 1'b0;
          state_d       = StIdle;
        end else if (cnt_q == ToLast) begin
          gnt_ctrl_d    = 1'b0;
          gnt_network_d = 1'b0;
          timeout_d     = 1'b1;
          last_d        = owner_q;
          state_d       = StIdle;
        end
      end
      StXfer: begin
        // Frames must be contiguous: the first idle cycle ends the frame.
        if (!own_wr) begin
          gnt_ctrl_d    = 1'b0;
          gnt_network_d = 1'b0;
          last_d        = owner_q;
          cnt_d         = '0;
          state_d       = StIfg;
        end
      end
      StIfg: begin
        if (cnt_q == IfgLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      owner_q       <= 1'b1;
      last_q        <= 1'b1;
      gnt_ctrl_q    <= 1'b0;
      gnt_network_q <= 1'b0;
      data_q        <= 8'h00;
      data_wr_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      gnt_ctrl_q    <= gnt_ctrl_d;
      gnt_network_q <= gnt_network_d;
      data_q        <= data_d;
      data_wr_q     <= data_wr_d;
      timeout_q     <= timeout_d;
    end
  end

  assign o_gnt_ctrl       = gnt_ctrl_q;
  assign o_gnt_network    = gnt_network_q;
  assign ov_data          = data_q;
  assign o_data_wr        = data_wr_q;
  assign o_interface_type = owner_q;
  assign o_timeout_pulse  = timeout_q;

endmodule

// File: tb/tb_interface_tx_arbiter_2to1.sv
// tb_interface_tx_arbiter_2to1
// Self-checking bench for interface_tx_arbiter_2to1: a vector table, directed multi-cycle
// sequences, and randomized source agents, all checked against a frame-level model that
// tracks grant deadlines as absolute cycle numbers.
module tb_interface_tx_arbiter_2to1;

  localparam int Ifg = 12;
  localparam int To  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_c = 1'b0, wr_c = 1'b0, req_n = 1'b0, wr_n = 1'b0;
  logic [7:0] data_c = 8'h00, data_n = 8'h00;
  logic       o_gnt_ctrl, o_gnt_network, o_data_wr, o_interface_type, o_timeout_pulse;
  logic [7:0] ov_data;

  always #4 clk = ~clk;

  interface_tx_arbiter_2to1 #(
    .IFG_CYCLES   (Ifg),
    .START_TIMEOUT(To)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_ctrl       (req_c),
    .o_gnt_ctrl       (o_gnt_ctrl),
    .iv_data_ctrl     (data_c),
    .i_data_wr_ctrl   (wr_c),
    .i_req_network    (req_n),
    .o_gnt_network    (o_gnt_network),
    .iv_data_network  (data_n),
    .i_data_wr_network(wr_n),
    .ov_data          (ov_data),
    .o_data_wr        (o_data_wr),
    .o_interface_type (o_interface_type),
    .o_timeout_pulse  (o_timeout_pulse)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: phase 0 = stream free, 1 = granted awaiting first byte, 2 = frame in progress.
  int         m_phase, m_free_at, m_gnt_at;
  bit         m_owner, m_last;
  bit         e_gc, e_gn, e_wr, e_it, e_p;
  logic [7:0] e_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_free_at = 0; m_gnt_at = 0; m_owner = 1'b1; m_last = 1'b1;
  endtask

  // Consume this cycle's inputs and predict the outputs seen after the next edge.
  task automatic model_step();
    bit         o_req, o_wr;
    logic [7:0] o_d;
    o_req = m_owner ? req_c : req_n;
    o_wr  = m_owner ? wr_c  : wr_n;
    o_d   = m_owner ? data_c : data_n;
    e_wr  = (m_phase != 0) && o_wr;
    e_d   = (m_phase != 0) ? o_d : 8'h00;
    e_p   = 1'b0;
    case (m_phase)
      0: if (cyc >= m_free_at && (req_c || req_n)) begin
        m_owner  = (req_c && req_n) ? !m_last : req_c;
        m_phase  = 1;
        m_gnt_at = cyc + 1;
      end
      1: if (o_wr) m_phase = 2;
        else if (!o_req) begin
          m_phase = 0; m_free_at = cyc + 1;
        end else if (cyc == m_gnt_at + To - 1) begin
          e_p = 1'b1; m_last = m_owner; m_phase = 0; m_free_at = cyc + 1;
        end
      default: if (!o_wr) begin
        m_last = m_owner; m_phase = 0; m_free_at = cyc + 1 + Ifg;
      end
    endcase
    e_gc = (m_phase != 0) && m_owner;
    e_gn = (m_phase != 0) && !m_owner;
    e_it = m_owner;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt_ctrl", o_gnt_ctrl, e_gc);
    chk("gnt_network", o_gnt_network, e_gn);
    chk("data_wr", o_data_wr, e_wr);
    chk("data", ov_data, e_d);
    chk("interface_type", o_interface_type, e_it);
    chk("timeout_pulse", o_timeout_pulse, e_p);
  endtask

  task automatic clear_inputs();
    req_c = 1'b0; wr_c = 1'b0; data_c = 8'h00;
    req_n = 1'b0; wr_n = 1'b0; data_n = 8'h00;
  endtask

  // Asserts reset away from the clock edge and checks the outputs clear before any edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_outputs", {o_gnt_ctrl, o_gnt_network, o_data_wr, ov_data, o_timeout_pulse}, 0);
    chk("rst_itype", o_interface_type, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  typedef struct {
    logic        rc, wc;
    logic [7:0]  dc;
    logic        rn, wn;
    logic [7:0]  dn;
    logic [12:0] exp;  // {gnt_ctrl, gnt_network, data_wr, data, itype, pulse}
  } vec_t;

  vec_t       tbl[6];
  int         owners[4], gaps[4];
  int         nfr, fall, sent_c, sent_n, nout;
  bit         prev_wr, ok;
  bit   [7:0] pat;
  bit         a_req[2], a_was_g[2], g[2], w[2];
  int         a_len[2], a_sent[2], a_wait[2], a_delay[2];
  logic [7:0] d[2];

  initial begin
    model_reset();
    do_reset();

    // Vector table: tie to network, non-owner 0xAA ignored, frame end, request during IFG.
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}};
    tbl[2] = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h11, {1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0}};
    tbl[3] = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h22, {1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0}};
    tbl[4] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      req_c = tbl[i].rc; wr_c = tbl[i].wc; data_c = tbl[i].dc;
      req_n = tbl[i].rn; wr_n = tbl[i].wn; data_n = tbl[i].dn;
      tick();
      chk($sformatf("vec%0d", i),
          {o_gnt_ctrl, o_gnt_network, o_data_wr, ov_data, o_interface_type, o_timeout_pulse},
          tbl[i].exp);
    end

    // Single 64-byte network frame while ctrl drives 0xAA without owning the stream.
    do_reset();
    req_n = 1'b1; wr_c = 1'b1; data_c = 8'hAA;
    tick();
    chk("a_grant_latency", o_gnt_network, 1);
    for (int i = 0; i < 64; i++) begin
      wr_n = 1'b1; data_n = 8'(i);
      tick();
      chk($sformatf("a_byte%0d", i), {o_data_wr, ov_data, o_interface_type}, {1'b1, 8'(i), 1'b0});
    end
    wr_n = 1'b0; req_n = 1'b0; wr_c = 1'b0;
    tick();
    chk("a_frame_end", {o_data_wr, o_gnt_network}, 0);

    // Both sources request continuously: owners alternate, gaps are IFG+2.
    do_reset();
    req_c = 1'b1; req_n = 1'b1; sent_c = 0; sent_n = 0; nfr = 0; prev_wr = 1'b0; fall = 0;
    for (int n = 0; n < 400 && nfr < 4; n++) begin
      if (!o_gnt_network) sent_n = 0;
      if (!o_gnt_ctrl) sent_c = 0;
      if (o_gnt_network && sent_n < 10) begin
        wr_n = 1'b1; data_n = 8'(sent_n + 16); sent_n++;
      end else wr_n = 1'b0;
      if (o_gnt_ctrl && sent_c < 10) begin
        wr_c = 1'b1; data_c = 8'(sent_c + 64); sent_c++;
      end else wr_c = 1'b0;
      tick();
      if (o_data_wr && !prev_wr) begin
        owners[nfr] = int'(o_interface_type);
        gaps[nfr] = cyc - fall;
        nfr++;
      end
      if (!o_data_wr && prev_wr) fall = cyc;
      prev_wr = o_data_wr;
    end
    chk("rr_frames", nfr, 4);
    for (int i = 0; i < nfr; i++) chk($sformatf("rr_owner%0d", i), owners[i], i % 2);
    for (int i = 1; i < nfr; i++) chk($sformatf("rr_gap%0d", i), gaps[i], Ifg + 2);

    // Wr gap mid-frame ends the frame; later bytes are dropped.
    do_reset();
    req_c = 1'b1;
    tick();
    chk("e_grant", o_gnt_ctrl, 1);
    pat = 8'b0111_0111;
    nout = 0;
    for (int i = 0; i < 8; i++) begin
      wr_c = pat[i]; data_c = 8'(i + 1);
      if (i == 3) req_c = 1'b0;
      tick();
      nout += int'(o_data_wr);
      if (i == 3) chk("e_grant_drop", o_gnt_ctrl, 0);
    end
    wr_c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      nout += int'(o_data_wr);
    end
    chk("e_bytes", nout, 3);

    // Reset during a ctrl frame after a completed network frame; first tie then goes to network.
    do_reset();
    req_n = 1'b1;
    tick();
    wr_n = 1'b1; data_n = 8'h31;
    tick();
    data_n = 8'h32;
    tick();
    wr_n = 1'b0; req_n = 1'b0;
    tick();
    for (int i = 0; i < Ifg + 1; i++) tick();
    req_c = 1'b1;
    tick();
    chk("f_grant_ctrl", o_gnt_ctrl, 1);
    for (int i = 0; i < 3; i++) begin
      wr_c = 1'b1; data_c = 8'(i + 8'h50);
      tick();
    end
    chk("f_mid_frame", o_data_wr, 1);
    do_reset();
    req_c = 1'b1; req_n = 1'b1;
    tick();
    chk("f_tie_after_reset", {o_gnt_network, o_gnt_ctrl}, 2'b10);

    // Ctrl granted but silent: timeout pulse at grant+64, pending network granted next.
    do_reset();
    req_c = 1'b1;
    tick();
    chk("c_grant", o_gnt_ctrl, 1);
    req_n = 1'b1;
    ok = 1'b1;
    for (int i = 1; i < To; i++) begin
      tick();
      if (o_timeout_pulse || !o_gnt_ctrl) ok = 1'b0;
    end
    chk("c_hold_until_timeout", ok, 1);
    tick();
    chk("c_timeout", {o_timeout_pulse, o_gnt_ctrl}, 2'b10);
    tick();
    chk("c_next_network", {o_gnt_network, o_timeout_pulse}, 2'b10);
    req_c = 1'b0; wr_n = 1'b1; data_n = 8'h05;
    tick();
    wr_n = 1'b0; req_n = 1'b0;
    tick();

    // Randomized agents against the model.
    do_reset();
    for (int a = 0; a < 2; a++) begin
      a_req[a] = 1'b0; a_was_g[a] = 1'b0;
    end
    for (int n = 0; n < 3000; n++) begin
      g[0] = o_gnt_network;
      g[1] = o_gnt_ctrl;
      for (int a = 0; a < 2; a++) begin
        w[a] = 1'b0;
        d[a] = 8'hAA;
        if (!a_req[a]) begin
          w[a] = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 5) == 0) begin
            a_req[a]   = 1'b1;
            a_len[a]   = int'($urandom_range(1, 8));
            a_delay[a] = ($urandom_range(0, 15) == 0) ? 70 : int'($urandom_range(0, 2));
            a_sent[a]  = 0;
            a_wait[a]  = 0;
          end
        end else if (!g[a]) begin
          w[a] = ($urandom_range(0, 3) == 0);
          if (a_was_g[a]) a_req[a] = 1'b0;
        end else if (a_wait[a] < a_delay[a]) begin
          a_wait[a]++;
          if ($urandom_range(0, 31) == 0) a_req[a] = 1'b0;
        end else if (a_sent[a] < a_len[a]) begin
          w[a] = 1'b1;
          d[a] = 8'($urandom);
          a_sent[a]++;
        end
        a_was_g[a] = g[a];
      end
      req_n = a_req[0]; wr_n = w[0]; data_n = d[0];
      req_c = a_req[1]; wr_c = w[1]; data_c = d[1];
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
